// File: rtl/ll_deq_sched_if.sv
// Handshake, linked_list and status bundle for ll_deq_sched.
// slave = scheduler side, master = environment (linked_list / clients).
interface ll_deq_sched_if #(
  parameter int NUM_QUEUES = 4,
  parameter int LL_DEPTH   = 64,
  parameter int DATA_WIDTH = 6
);
  localparam int QW = $clog2(NUM_QUEUES);
  localparam int CW = $clog2(LL_DEPTH + 1);

  logic                     init_done;
  logic                     enq_vld_in;
  logic [QW-1:0]            enq_id_in;
  logic [DATA_WIDTH-1:0]    enq_data_in;
  logic                     enq_rdy_out;
  logic [NUM_QUEUES-1:0]    deq_req_in;
  logic [NUM_QUEUES-1:0]    deq_gnt_out;
  logic                     ll_enq_vld_out;
  logic [QW-1:0]            ll_enq_id_out;
  logic [DATA_WIDTH-1:0]    ll_enq_data_out;
  logic                     ll_deq_vld_out;
  logic [QW-1:0]            ll_deq_id_out;
  logic [DATA_WIDTH-1:0]    ll_deq_data_in;
  logic                     rsp_vld_out;
  logic [QW-1:0]            rsp_id_out;
  logic [DATA_WIDTH-1:0]    rsp_data_out;
  logic [NUM_QUEUES*CW-1:0] queue_cnt_out;
  logic [CW-1:0]            global_cnt_out;
  logic                     err_out;

  modport slave (
    input  init_done, enq_vld_in, enq_id_in, enq_data_in, deq_req_in, ll_deq_data_in,
    output enq_rdy_out, deq_gnt_out, ll_enq_vld_out, ll_enq_id_out, ll_enq_data_out,
           ll_deq_vld_out, ll_deq_id_out, rsp_vld_out, rsp_id_out, rsp_data_out,
           queue_cnt_out, global_cnt_out, err_out
  );

  modport master (
    output init_done, enq_vld_in, enq_id_in, enq_data_in, deq_req_in, ll_deq_data_in,
    input  enq_rdy_out, deq_gnt_out, ll_enq_vld_out, ll_enq_id_out, ll_enq_data_out,
           ll_deq_vld_out, ll_deq_id_out, rsp_vld_out, rsp_id_out, rsp_data_out,
           queue_cnt_out, global_cnt_out, err_out
  );
endinterface

// File: rtl/ll_deq_sched.sv
// Enqueue admission, dequeue arbitration and response tagging for the multi-queue linked_list.
// Define LL_DEQ_SCHED_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
//
// state  | meaning
// S_INIT | linked_list still initialising; no ready, valid or grant
// S_RUN  | normal operation; left only through reset
module ll_deq_sched #(
  parameter int NUM_QUEUES = 4,
  parameter int LL_DEPTH   = 64,
  parameter int DATA_WIDTH = 6,
  parameter int READ_DELAY = 3,
  parameter int DEQ_GAP    = 2
) (
  input  logic          clk,
  input  logic          reset,
  ll_deq_sched_if.slave bus
);
  localparam int QW = $clog2(NUM_QUEUES);
  localparam int CW = $clog2(LL_DEPTH + 1);
  localparam int GW = (DEQ_GAP > 0) ? $clog2(DEQ_GAP + 1) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic                  w_run, w_enq_rdy, w_enq_acc, w_issue, w_any;
  logic [QW-1:0]         w_win;
  logic [NUM_QUEUES-1:0] w_elig, w_gnt;
  logic [CW-1:0]         r_qcnt [NUM_QUEUES];
  logic [CW-1:0]         r_gcnt;
  logic [GW-1:0]         r_gap;
  logic                  r_err;
  logic                  r_ll_enq_vld, r_ll_deq_vld;
  logic [QW-1:0]         r_ll_enq_id, r_ll_deq_id;
  logic [DATA_WIDTH-1:0] r_ll_enq_data;
  logic [READ_DELAY-1:0] r_pv;
  logic [QW-1:0]         r_pid [READ_DELAY];
  logic                  r_rsp_vld;
  logic [QW-1:0]         r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  // One entry of the pool is held back so the linked_list never fills completely.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      S_INIT:  if (bus.init_done) w_state_nxt = S_RUN;
      S_RUN:   w_run = 1'b1;
      default: w_state_nxt = S_INIT;
    endcase
    w_enq_rdy = w_run && (r_gcnt < CW'(LL_DEPTH - 1));
    w_enq_acc = w_enq_rdy && bus.enq_vld_in;
    w_issue   = w_run && (r_gap == '0) && w_any;
  end

  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++)
      w_elig[i] = bus.deq_req_in[i] && (r_qcnt[i] != '0);
  end

`ifdef LL_DEQ_SCHED_STRICT_PRIO_EN
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win = QW'(i);
        w_any = 1'b1;
      end
    end
  end
`else
  logic [QW-1:0] r_ptr;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      if (!w_any && w_elig[(int'(r_ptr) + k) % NUM_QUEUES]) begin
        w_win = QW'((int'(r_ptr) + k) % NUM_QUEUES);
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_ptr <= QW'(NUM_QUEUES - 1);
    else if (w_issue) r_ptr <= w_win;
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++)
      w_gnt[i] = w_issue && (w_win == QW'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) r_qcnt[i] <= '0;
      r_gcnt <= '0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (w_enq_acc && (bus.enq_id_in == QW'(i)) && !w_gnt[i])
          r_qcnt[i] <= r_qcnt[i] + CW'(1);
        else if (w_gnt[i] && !(w_enq_acc && (bus.enq_id_in == QW'(i))))
          r_qcnt[i] <= r_qcnt[i] - CW'(1);
      end
      if (w_enq_acc && !w_issue)      r_gcnt <= r_gcnt + CW'(1);
      else if (!w_enq_acc && w_issue) r_gcnt <= r_gcnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_gap <= '0;
    else if (w_issue)       r_gap <= GW'(DEQ_GAP);
    else if (r_gap != '0)   r_gap <= r_gap - GW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            r_err <= 1'b0;
    else if (bus.enq_vld_in && !w_enq_rdy) r_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ll_enq_vld  <= 1'b0;
      r_ll_enq_id   <= '0;
      r_ll_enq_data <= '0;
      r_ll_deq_vld  <= 1'b0;
      r_ll_deq_id   <= '0;
    end else begin
      r_ll_enq_vld <= w_enq_acc;
      r_ll_deq_vld <= w_issue;
      if (w_enq_acc) begin
        r_ll_enq_id   <= bus.enq_id_in;
        r_ll_enq_data <= bus.enq_data_in;
      end
      if (w_issue) r_ll_deq_id <= w_win;
    end
  end

  // Tag pipeline lines up with the linked_list read latency; the last stage marks the data cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pv <= '0;
      for (int i = 0; i < READ_DELAY; i++) r_pid[i] <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else begin
      r_pv[0]  <= r_ll_deq_vld;
      r_pid[0] <= r_ll_deq_id;
      for (int i = 1; i < READ_DELAY; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
      r_rsp_vld <= r_pv[READ_DELAY-1];
      if (r_pv[READ_DELAY-1]) begin
        r_rsp_id   <= r_pid[READ_DELAY-1];
        r_rsp_data <= bus.ll_deq_data_in;
      end
    end
  end

  assign bus.enq_rdy_out     = w_enq_rdy;
  assign bus.deq_gnt_out     = w_gnt;
  assign bus.ll_enq_vld_out  = r_ll_enq_vld;
  assign bus.ll_enq_id_out   = r_ll_enq_id;
  assign bus.ll_enq_data_out = r_ll_enq_data;
  assign bus.ll_deq_vld_out  = r_ll_deq_vld;
  assign bus.ll_deq_id_out   = r_ll_deq_id;
  assign bus.rsp_vld_out     = r_rsp_vld;
  assign bus.rsp_id_out      = r_rsp_id;
  assign bus.rsp_data_out    = r_rsp_data;
  assign bus.global_cnt_out  = r_gcnt;
  assign bus.err_out         = r_err;

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_qcnt
    assign bus.queue_cnt_out[g*CW +: CW] = r_qcnt[g];
  end
endmodule

// File: tb/tb_ll_deq_sched.sv
// Scoreboard bench for ll_deq_sched with a behavioural linked_list model behind it.
// Expected payloads are queued per queue at enqueue time and popped on each tagged response.
module tb_ll_deq_sched;
  localparam int NQ = 4, DEPTH = 64, DW = 6, RD = 3, GAP = 2;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct {int c; int d;} pend_t;
  typedef struct {int c0; int id;} lat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0, n_chk = 0, n_fail = 0;
  int   sb_q [NQ][$];
  int   ll_mem [NQ][$];
  pend_t pend [$];
  lat_t  exp_lat [$];
  int   gnt_c [$];
  int   gnt_i [$];
  int   last_rsp_id, last_rsp_data, last_rsp_lat;

  ll_deq_sched_if #(.NUM_QUEUES(NQ), .LL_DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  ll_deq_sched #(.NUM_QUEUES(NQ), .LL_DEPTH(DEPTH), .DATA_WIDTH(DW),
                 .READ_DELAY(RD), .DEQ_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // linked_list model plus response / grant monitor
  always @(negedge clk) begin
    int   d;
    lat_t e;
    if (reset) begin
      if (bus.ll_enq_vld_out) ll_mem[bus.ll_enq_id_out].push_back(int'(bus.ll_enq_data_out));
      if (bus.ll_deq_vld_out) begin
        d = 0;
        if (ll_mem[bus.ll_deq_id_out].size() > 0) d = ll_mem[bus.ll_deq_id_out].pop_front();
        pend.push_back('{cyc + RD, d});
        exp_lat.push_back('{cyc, int'(bus.ll_deq_id_out)});
      end
      if (bus.deq_gnt_out != '0) begin
        chk("gnt_onehot", 32'($onehot(bus.deq_gnt_out)), 1);
        for (int i = 0; i < NQ; i++)
          if (bus.deq_gnt_out[i]) begin gnt_c.push_back(cyc); gnt_i.push_back(i); end
      end
      if (bus.rsp_vld_out) begin
        if (exp_lat.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = exp_lat.pop_front();
          last_rsp_lat  = cyc - e.c0;
          last_rsp_id   = int'(bus.rsp_id_out);
          last_rsp_data = int'(bus.rsp_data_out);
          chk("rsp_latency", last_rsp_lat, RD + 1);
          chk("rsp_id", bus.rsp_id_out, e.id);
          if (sb_q[bus.rsp_id_out].size() == 0) chk("rsp_no_expected", 1, 0);
          else chk("rsp_data", bus.rsp_data_out, sb_q[bus.rsp_id_out].pop_front());
        end
      end
    end
    if (pend.size() > 0 && pend[0].c == cyc) begin
      bus.ll_deq_data_in = DW'(pend[0].d);
      void'(pend.pop_front());
    end else begin
      bus.ll_deq_data_in = DW'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_rdy", bus.enq_rdy_out, 0);
    chk("rst_gnt", bus.deq_gnt_out, 0);
    chk("rst_ll_vld", {bus.ll_enq_vld_out, bus.ll_deq_vld_out}, 0);
    chk("rst_rsp", {bus.rsp_vld_out, bus.rsp_id_out, bus.rsp_data_out}, 0);
    chk("rst_cnt", {bus.global_cnt_out, bus.queue_cnt_out}, 0);
    chk("rst_err", bus.err_out, 0);
    for (int i = 0; i < NQ; i++) begin sb_q[i].delete(); ll_mem[i].delete(); end
    pend.delete(); exp_lat.delete(); gnt_c.delete(); gnt_i.delete();
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic go_run();
    bus.init_done = 1'b1;
    step();
  endtask

  task automatic enq(input int q, input int d);
    bus.enq_vld_in  = 1'b1;
    bus.enq_id_in   = q[1:0];
    bus.enq_data_in = DW'(d);
    if (bus.enq_rdy_out) sb_q[q].push_back(d);
    step();
    bus.enq_vld_in = 1'b0;
  endtask

  task automatic wait_drain(input int maxc, input string tag);
    int n = 0;
    while (!(bus.global_cnt_out == '0 && !bus.ll_deq_vld_out && exp_lat.size() == 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) chk({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    int n;
    bus.init_done = 1'b0; bus.enq_vld_in = 1'b0; bus.enq_id_in = '0;
    bus.enq_data_in = '0; bus.deq_req_in = '0;
    apply_reset();

    // held in INIT with traffic pending
    bus.enq_vld_in = 1'b1; bus.enq_id_in = 2'd1; bus.enq_data_in = 6'h05; bus.deq_req_in = 4'hF;
    repeat (10) begin
      step();
      chk("init_rdy", bus.enq_rdy_out, 0);
      chk("init_vld", {bus.ll_enq_vld_out, bus.ll_deq_vld_out, bus.deq_gnt_out}, 0);
    end
    bus.enq_vld_in = 1'b0; bus.deq_req_in = '0;
    chk("init_err", bus.err_out, 1);
    bus.init_done = 1'b1;
    step();
    chk("run_rdy", bus.enq_rdy_out, 1);
    bus.init_done = 1'b0;
    step();
    chk("run_ignores_init", bus.enq_rdy_out, 1);

    // fill queue 2 up to the reservation limit, then drain it
    apply_reset();
    go_run();
    for (int i = 0; i < 63; i++) enq(2, i);
    chk("fill_err_pre", bus.err_out, 0);
    chk("fill_gcnt", bus.global_cnt_out, 63);
    chk("fill_qcnt2", bus.queue_cnt_out[2*CW +: CW], 63);
    bus.enq_vld_in = 1'b1; bus.enq_id_in = 2'd2; bus.enq_data_in = 6'h3F;
    chk("full_rdy", bus.enq_rdy_out, 0);
    step();
    bus.enq_vld_in = 1'b0;
    chk("full_err", bus.err_out, 1);
    chk("full_gcnt", bus.global_cnt_out, 63);
    chk("full_qcnt2", bus.queue_cnt_out[2*CW +: CW], 63);
    chk("full_no_ll_enq", bus.ll_enq_vld_out, 0);
    bus.deq_req_in = 4'b0100;
    wait_drain(400, "fill_drain");
    bus.deq_req_in = '0;
    chk("fill_sb_empty", sb_q[2].size(), 0);
    chk("fill_qcnt2_end", bus.queue_cnt_out[2*CW +: CW], 0);

    // one entry per queue, all requesting
    apply_reset();
    go_run();
    for (int q = 0; q < NQ; q++) enq(q, 10 + q);
    bus.deq_req_in = 4'hF;
    wait_drain(100, "arb_drain");
    bus.deq_req_in = '0;
    chk("arb_ngnt", gnt_i.size(), 4);
    if (gnt_i.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk("arb_order", gnt_i[k], k);
        if (k > 0) chk("arb_spacing", gnt_c[k] - gnt_c[k-1], GAP + 1);
      end

    // two entries in q0 against one in q1
    gnt_c.delete(); gnt_i.delete();
    enq(0, 20); enq(0, 21); enq(1, 22);
    bus.deq_req_in = 4'b0011;
    wait_drain(100, "prio_drain");
    bus.deq_req_in = '0;
    chk("prio_ngnt", gnt_i.size(), 3);
    if (gnt_i.size() == 3) begin
`ifdef LL_DEQ_SCHED_STRICT_PRIO_EN
      chk("prio_g0", gnt_i[0], 0); chk("prio_g1", gnt_i[1], 0); chk("prio_g2", gnt_i[2], 1);
`else
      chk("prio_g0", gnt_i[0], 0); chk("prio_g1", gnt_i[1], 1); chk("prio_g2", gnt_i[2], 0);
`endif
    end

    // same-cycle enqueue does not make a queue eligible
    repeat (4) step();
    bus.deq_req_in = 4'b0010;
    bus.enq_vld_in = 1'b1; bus.enq_id_in = 2'd1; bus.enq_data_in = 6'h15;
    if (bus.enq_rdy_out) sb_q[1].push_back('h15);
    @(negedge clk);
    chk("elig_same_cycle", bus.deq_gnt_out, 4'b0000);
    step();
    bus.enq_vld_in = 1'b0;
    @(negedge clk);
    chk("elig_next_cycle", bus.deq_gnt_out, 4'b0010);
    step();
    bus.deq_req_in = '0;
    wait_drain(50, "elig_drain");

    // tagged response from q3
    last_rsp_id = -1; last_rsp_data = -1; last_rsp_lat = -1;
    enq(3, 'h2A);
    bus.deq_req_in = 4'b1000;
    wait_drain(50, "rsp_drain");
    bus.deq_req_in = '0;
    chk("rsp_q3_id", last_rsp_id, 3);
    chk("rsp_q3_data", last_rsp_data, 'h2A);
    chk("rsp_q3_lat", last_rsp_lat, RD + 1);

    // reset with two responses in flight
    enq(0, 1); enq(0, 2);
    bus.deq_req_in = 4'b0001;
    n = 0;
    while (!(bus.ll_deq_vld_out && exp_lat.size() == 1) && n < 40) begin step(); n++; end
    if (n >= 40) chk("flight_wait_timeout", 1, 0);
    bus.deq_req_in = '0;
    bus.init_done = 1'b0;
    #2;
    apply_reset();
    repeat (8) begin
      step();
      chk("post_rst_rsp", bus.rsp_vld_out, 0);
      chk("post_rst_init", bus.enq_rdy_out, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ll_deq_sched.md
Name: ll_deq_sched

Overview:
Controller in front of the multi-queue linked_list.
- Holds off all traffic until the list finishes init.
- Admits enqueues only while the shared pool has room; tracks per-queue and global occupancy.
- Arbitrates per-queue dequeue requests (round-robin), never dequeues an empty queue, and rate-limits dequeue issue.
- Tags the delayed linked_list read data with its queue id and a valid.

Parameters:
NUM_QUEUES, 4, number of logical queues in the linked list
LL_DEPTH, 64, total linked-list entries
DATA_WIDTH, 6, payload width
READ_DELAY, 3, linked_list dequeue-to-data latency in cycles
DEQ_GAP, 2, minimum idle cycles between dequeue issues
(derived) QW = $clog2(NUM_QUEUES), CW = $clog2(LL_DEPTH+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
init_done  in  1  linked_list init complete
enq_vld_in  in  1  enqueue request
enq_id_in  in  QW  target queue
enq_data_in  in  DATA_WIDTH  payload
enq_rdy_out  out  1  enqueue accepted when enq_vld_in & enq_rdy_out
deq_req_in  in  NUM_QUEUES  per-queue dequeue request, level
deq_gnt_out  out  NUM_QUEUES  one-hot grant pulse
ll_enq_vld_out / ll_enq_id_out / ll_enq_data_out  out  1/QW/DATA_WIDTH  to linked_list
ll_deq_vld_out / ll_deq_id_out  out  1/QW  to linked_list
ll_deq_data_in  in  DATA_WIDTH  linked_list deq_data_out
rsp_vld_out / rsp_id_out / rsp_data_out  out  1/QW/DATA_WIDTH  tagged dequeue response
queue_cnt_out  out  NUM_QUEUES*CW  per-queue occupancy, packed, queue 0 in LSBs
global_cnt_out  out  CW  total occupancy
err_out  out  1  sticky: enqueue attempted while not ready

Behaviour:
- Reset (reset=0, async): all outputs 0, counts 0, pipeline cleared, gap counter 0, RR pointer = NUM_QUEUES-1, state INIT.
- FSM INIT: all ready/valid/grant outputs held 0. Move to RUN on the first clk edge where init_done=1. init_done is ignored while in RUN.
- FSM RUN to INIT: only via reset.
- Enqueue:
  - enq_rdy_out = RUN & (global_cnt < LL_DEPTH-1). One entry is reserved.
  - On accept: ll_enq_* registered, driven the next cycle for exactly 1 cycle; queue_cnt[id]+1 and global_cnt+1 at that edge.
  - enq_vld_in while not ready: dropped, no count change; err_out set, cleared only by reset.
- Dequeue eligibility: deq_req_in[i] & queue_cnt[i]!=0, using registered counts. A same-cycle enqueue does not make a queue eligible.
- Issue condition: RUN & gap counter == 0 & any eligible queue.
- Round-robin: search starts at pointer+1 with wrap; the first eligible queue wins. Pointer updates to the winner only on grant.
- On grant:
  - deq_gnt_out one-hot for 1 cycle, combinational from registered state.
  - ll_deq_vld_out/ll_deq_id_out registered, asserted next cycle for 1 cycle.
  - queue_cnt[i]-1 and global_cnt-1.
  - Gap counter loads DEQ_GAP and decrements to 0. DEQ_GAP=0 allows back-to-back issue.
- Simultaneous enq and deq, same or different queue: both applied. Net count change 0 on the same queue; global unchanged.
- Response path:
  - READ_DELAY-deep shift register of {vld,id}, fed from ll_deq_vld_out/ll_deq_id_out.
  - ll_deq_data_in is sampled at edge READ_DELAY after the ll_deq_vld_out cycle.
  - rsp_* registered: rsp_vld_out high for 1 cycle, READ_DELAY+1 cycles after ll_deq_vld_out, carrying the matching id.
- Counters never wrap. Underflow is prevented by eligibility; overflow by the reservation.
- Reset mid-operation discards in-flight responses. The linked_list is required to be reset concurrently.

Optional Feature:
LL_DEQ_SCHED_STRICT_PRIO_EN
- Defined: fixed priority, lowest eligible index wins; RR pointer removed.
- Undefined: round-robin as above.
- Both modes: eligibility, gap, and latency rules are unchanged.

Test Plan:
- Hold init_done=0 for 10 cycles with enq/deq requests active -> enq_rdy_out=0, no ll_* valids; init_done=1 -> RUN, enq_rdy_out=1 next cycle.
- Enqueue 63 entries to queue 2 -> 64th attempt sees enq_rdy_out=0, err_out=1, global_cnt_out=63, queue_cnt[2]=63.
- Enqueue 1 entry to each of q0..q3, deq_req_in=4'b1111 constant, DEQ_GAP=2 -> grants q0,q1,q2,q3 spaced 3 cycles apart; with STRICT_PRIO_EN, same sequence, but q0 always wins while it is non-empty.
- deq_req_in[1]=1, queue 1 empty, enqueue to q1 at cycle t -> no grant at t; grant at t+1, after the count registers.
- Dequeue q3 holding value 0x2A -> rsp_vld_out=1, rsp_id_out=3, rsp_data_out=0x2A exactly READ_DELAY+1=4 cycles after ll_deq_vld_out.
- Assert reset mid-stream with 2 responses in flight -> all outputs 0 immediately, no rsp_vld_out afterward, state INIT.
